mem_write_arbiter: RTL

// - Shares the single write port of the unified memory between NUM_REQ requesters (core store unit, program loader, ...).
// - Round-robin arbitration; captures the winning request into a holding register, then drives the memory write port until the memory accepts it.
// - Returns a per-requester accept pulse and a per-requester commit pulse.
// - Sits between requesters and memory write_addr/write_data/bytes_to_write/write_activate/write_done.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/rr_pick.sv | 28 ++
 rtl/mem_write_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified-memory write arbiter.
package mem_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIW_DEF        = $clog2(DATA_WIDTH_DEF / 8);

    // One write request as seen at the memory write port.
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [DIW_DEF:0]          bytes;
    } wr_req_t;

    // Arbiter FSM states: IDLE has nothing held, ISSUE drives the memory port.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Byte counts above the port width are saturated to the port width.
    function automatic logic [31:0] clamp_bytes(input logic [31:0] req_bytes_v,
                                                input logic [31:0] max_bytes_v);
        logic [31:0] res_v;
        if (req_bytes_v > max_bytes_v) begin
            res_v = max_bytes_v;
        end else begin
            res_v = req_bytes_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
    import mem_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDXW-1:0]    ptr,
    output logic [IDXW-1:0]    grant,
    output logic               any
);

    // Scan offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        int          sum_v;
        logic [IDXW-1:0] idx_v;
        grant = {IDXW{1'b0}};
        any   = |valid;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum_v = int'(ptr) + off;
            sum_v = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
            idx_v = IDXW'(sum_v);
            grant = valid[idx_v] ? idx_v : grant;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares the single memory write port between NUM_REQ requesters.
// The round-robin winner is captured into a holding register that drives
// the memory port until write_done; a new winner can be captured in the
// same cycle as write_done so back-to-back writes keep activate high.
module mem_write_arbiter
    import mem_pkg::*;
#(
    parameter  int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter  int NUM_REQ        = 2,
    localparam int DATA_BYTE_SIZE = DATA_WIDTH / 8,
    localparam int DIW            = $clog2(DATA_BYTE_SIZE),
    localparam int BW             = DIW + 1,
    localparam int IDXW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0][BW-1:0]         req_bytes,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [ADDR_WIDTH-1:0]              mem_write_addr,
    output logic [DATA_WIDTH-1:0]              mem_write_data,
    output logic [BW-1:0]                      mem_bytes_to_write,
    output logic                               mem_write_activate,
    input  logic                               mem_write_done,
    output logic                               busy
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e               state_r;
    logic [IDXW-1:0]          rr_ptr_r;
    logic [IDXW-1:0]          owner_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [DATA_WIDTH-1:0]    data_r;
    logic [BW-1:0]            bytes_r;
    logic                     activate_r;
    logic [NUM_REQ-1:0]       done_r;

    logic [IDXW-1:0]          grant_s;
    logic                     any_s;
    logic                     accept_s;
    logic                     finish_s;
    logic [BW-1:0]            grant_bytes_s;
    logic                     grant_zero_s;
    logic [IDXW-1:0]          ptr_next_s;
    logic [NUM_REQ-1:0]       grant_mask_s;
    logic [NUM_REQ-1:0]       owner_mask_s;
    logic [NUM_REQ-1:0]       done_next_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .any   (any_s)
    );

    // A grant is taken when nothing is held, or the held write lands this cycle.
    always_comb begin
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = any_s & ~rst;
                finish_s = 1'b0;
            end
            ISSUE: begin
                accept_s = any_s & mem_write_done & ~rst;
                finish_s = mem_write_done;
            end
            default: begin
                accept_s = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Winner fields, next pointer and one-hot masks for ready/done.
    always_comb begin
        grant_bytes_s = BW'(clamp_bytes(32'(req_bytes[grant_s]), 32'(DATA_BYTE_SIZE)));
        grant_zero_s  = (grant_bytes_s == {BW{1'b0}});
        ptr_next_s    = (grant_s == IDXW'(NUM_REQ - 1)) ? {IDXW{1'b0}} : (grant_s + IDXW'(1'b1));
        grant_mask_s  = ONE_HOT0 << grant_s;
        owner_mask_s  = ONE_HOT0 << owner_r;
        done_next_s   = (finish_s ? owner_mask_s : {NUM_REQ{1'b0}})
                      | ((accept_s && grant_zero_s) ? grant_mask_s : {NUM_REQ{1'b0}});
        req_ready     = accept_s ? grant_mask_s : {NUM_REQ{1'b0}};
    end

    // Holding register: loads the winning request on every accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            bytes_r <= {BW{1'b0}};
        end else if (accept_s) begin
            addr_r  <= req_addr[grant_s];
            data_r  <= req_data[grant_s];
            bytes_r <= grant_bytes_s;
        end else begin
            addr_r  <= addr_r;
            data_r  <= data_r;
            bytes_r <= bytes_r;
        end
    end

    // Arbiter FSM: state, memory activate, round-robin pointer, owner, done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            activate_r <= 1'b0;
            rr_ptr_r   <= {IDXW{1'b0}};
            owner_r    <= {IDXW{1'b0}};
            done_r     <= {NUM_REQ{1'b0}};
        end else begin
            done_r <= done_next_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r    <= grant_s;
                        rr_ptr_r   <= ptr_next_s;
                        state_r    <= grant_zero_s ? IDLE : ISSUE;
                        activate_r <= ~grant_zero_s;
                    end else begin
                        state_r    <= IDLE;
                        activate_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (accept_s) begin
                        owner_r    <= grant_s;
                        rr_ptr_r   <= ptr_next_s;
                        state_r    <= grant_zero_s ? IDLE : ISSUE;
                        activate_r <= ~grant_zero_s;
                    end else if (mem_write_done) begin
                        state_r    <= IDLE;
                        activate_r <= 1'b0;
                    end else begin
                        state_r    <= ISSUE;
                        activate_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    activate_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_write_addr     = addr_r;
    assign mem_write_data     = data_r;
    assign mem_bytes_to_write = bytes_r;
    assign mem_write_activate = activate_r;
    assign req_done           = done_r;
    assign busy               = (state_r == ISSUE);

endmodule
